// File: rtl/direction_input_ctrl_pkg.sv
// Shared direction encoding and turn-acceptance helpers for the joystick front end.
// The `*_DIR macros are the codebase-wide encoding also used by game_logic.
`ifndef DIRECTION_DEFINES_SVH
`define DIRECTION_DEFINES_SVH
`define TOP_DIR    2'b00
`define RIGHT_DIR  2'b01
`define BOTTOM_DIR 2'b10
`define LEFT_DIR   2'b11
`define REVERSE_DIR(d) ((d) ^ 2'b10)
`endif

package direction_input_ctrl_pkg;

    typedef logic [1:0] dir_t;

    localparam int NUM_BTNS = 4;
    localparam int QDEPTH   = 2;

    localparam dir_t DIR_TOP    = `TOP_DIR;
    localparam dir_t DIR_RIGHT  = `RIGHT_DIR;
    localparam dir_t DIR_BOTTOM = `BOTTOM_DIR;
    localparam dir_t DIR_LEFT   = `LEFT_DIR;

    typedef struct packed {
        logic vld;
        dir_t dir;
    } turn_req_t;

    function automatic dir_t reverse_dir(input dir_t d);
        return `REVERSE_DIR(d);
    endfunction

    // A turn is only useful if it neither repeats nor reverses the reference heading.
    function automatic logic is_turn(input dir_t req_dir, input dir_t ref_dir);
        return (req_dir != ref_dir) && (req_dir != reverse_dir(ref_dir));
    endfunction

endpackage

// File: rtl/direction_input_ctrl_btn_debouncer.sv
// One button: 2-FF synchroniser, stability counter and a registered 1-cycle press pulse.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          stable_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn};
            stable_d <= stable;
            press    <= stable & ~stable_d;
            // Any sample agreeing with the stable level restarts the qualification window.
            if (sync_q[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_q[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/direction_input_ctrl.sv
// Joystick to game_logic heading: debounced presses, turn filtering and a 2-deep turn queue
// drained one entry per move_tick so direction only ever changes on a snake step.
module direction_input_ctrl
    import direction_input_ctrl_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 250000,
    parameter dir_t INIT_DIR        = DIR_TOP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       move_tick,
    output logic [1:0] direction,
    output logic       dir_changed,
    output logic [1:0] pending,
    output logic       req_dropped
);
    // Bit index equals the encoded direction of that button.
    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press;

    assign btn_raw = {btn_left, btn_down, btn_right, btn_up};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .btn  (btn_raw[i]),
            .press(press[i])
        );
    end

    // Lowest index wins: up > right > down > left.
    turn_req_t req;

    always_comb begin
        req = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (press[i]) begin
                req.vld = 1'b1;
                req.dir = dir_t'(i);
            end
        end
    end

    dir_t [QDEPTH-1:0] q;
    dir_t              ref_dir;
    logic              full;
    logic              accept;
    logic              pop;

    // Reference is the last heading the snake will have taken, sampled ahead of any pop.
    assign ref_dir = (pending == 2'd2) ? q[1] : (pending == 2'd1) ? q[0] : direction;
    assign full    = (pending == 2'd2);
    assign accept  = req.vld && is_turn(req.dir, ref_dir);
    assign pop     = move_tick && (pending != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            direction   <= INIT_DIR;
            pending     <= 2'd0;
            q           <= '0;
            dir_changed <= 1'b0;
            req_dropped <= 1'b0;
        end else begin
            dir_changed <= pop;
            req_dropped <= accept && full && !pop;
            if (pop) direction <= q[0];
            case ({pop, accept})
                2'b10: begin
                    q[0]    <= q[1];
                    pending <= pending - 2'd1;
                end
                2'b01: begin
                    if (!full) begin
                        q[pending[0]] <= req.dir;
                        pending       <= pending + 2'd1;
                    end
                end
                // Pop and push together: occupancy holds, the new turn lands at the tail.
                2'b11: begin
                    if (full) begin
                        q[0] <= q[1];
                        q[1] <= req.dir;
                    end else begin
                        q[0] <= req.dir;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Self-checking bench for direction_input_ctrl with DEBOUNCE_CYCLES=4.
module tb_direction_input_ctrl;
    import direction_input_ctrl_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_right, btn_down, btn_left;
    logic       move_tick;
    logic [1:0] direction;
    logic       dir_changed;
    logic [1:0] pending;
    logic       req_dropped;

    int n_cmp = 0;
    int n_err = 0;

    dir_t exp_q[$];   // directions expected to be applied, in order
    dir_t mq[$];      // model of the turn queue
    dir_t m_dir;

    always #5 clk = ~clk;

    direction_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .INIT_DIR       (DIR_TOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .move_tick  (move_tick),
        .direction  (direction),
        .dir_changed(dir_changed),
        .pending    (pending),
        .req_dropped(req_dropped)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btns(input logic [3:0] m);
        {btn_left, btn_down, btn_right, btn_up} = m;
    endtask

    // Transaction-level model of one clock edge with a press mask and a tick.
    task automatic model_edge(input logic tick, input logic [3:0] pmask, output logic drop);
        dir_t rq;
        dir_t rf;
        logic acc;
        logic popd;
        int   sz;
        sz   = mq.size();
        rq   = DIR_TOP;
        acc  = 1'b0;
        drop = 1'b0;
        rf   = (sz > 0) ? mq[sz-1] : m_dir;
        for (int i = 3; i >= 0; i--) begin
            if (pmask[i]) begin
                acc = 1'b1;
                rq  = dir_t'(i);
            end
        end
        acc  = acc && (rq != rf) && (rq != (rf ^ 2'b10));
        popd = tick && (sz > 0);
        if (popd) begin
            m_dir = mq.pop_front();
            exp_q.push_back(m_dir);
        end
        if (acc) begin
            if (sz < 2 || popd) mq.push_back(rq);
            else drop = 1'b1;
        end
    endtask

    // Scoreboard: every dir_changed pulse must match the next expected heading.
    always @(negedge clk) begin
        if (!reset && dir_changed) begin
            if (exp_q.size() == 0) chk("dc_spurious", int'(dir_changed), 0);
            else chk("sb_dir", int'(direction), int'(exp_q.pop_front()));
        end
    end

    task automatic press(input logic [3:0] m, input logic tick_at_pulse, input string tag);
        logic drop;
        int   sz0;
        sz0 = mq.size();
        set_btns(m);
        step(2 + D + 1);
        chk({tag, "_pre"}, int'(pending), sz0);
        move_tick = tick_at_pulse;
        step(1);
        move_tick = 1'b0;
        model_edge(tick_at_pulse, m, drop);
        chk({tag, "_pend"}, int'(pending), mq.size());
        chk({tag, "_drop"}, int'(req_dropped), int'(drop));
        chk({tag, "_dir"}, int'(direction), int'(m_dir));
        set_btns(4'b0);
        step(1);
        chk({tag, "_droplen"}, int'(req_dropped), 0);
        step(2 + D + 3);
        chk({tag, "_hold"}, int'(pending), mq.size());
    endtask

    task automatic tick(input string tag);
        logic drop;
        int   sz0;
        sz0 = mq.size();
        move_tick = 1'b1;
        step(1);
        move_tick = 1'b0;
        model_edge(1'b1, 4'b0, drop);
        chk({tag, "_dir"}, int'(direction), int'(m_dir));
        chk({tag, "_pend"}, int'(pending), mq.size());
        chk({tag, "_dc"}, int'(dir_changed), int'(sz0 > 0));
        step(1);
        chk({tag, "_dcoff"}, int'(dir_changed), 0);
    endtask

    initial begin
        logic drop;
        reset     = 1'b1;
        move_tick = 1'b0;
        set_btns(4'b0);
        m_dir = DIR_TOP;
        step(3);
        reset = 1'b0;
        chk("rst_dir", int'(direction), int'(DIR_TOP));
        chk("rst_pend", int'(pending), 0);
        chk("rst_dc", int'(dir_changed), 0);
        chk("rst_drop", int'(req_dropped), 0);

        // Latency: press visible after 7 edges, queued on the 8th.
        press(4'b0010, 1'b0, "right");
        tick("t_right");

        // Bouncing up button must not register.
        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            step(2);
        end
        step(10);
        chk("bounce_none", int'(pending), 0);
        btn_up = 1'b1;
        step(6);
        btn_up = 1'b0;
        step(2);
        model_edge(1'b0, 4'b0001, drop);
        step(10);
        chk("bounce_one", int'(pending), mq.size());
        tick("t_up");

        // Same-direction and reversal rejection from TOP.
        press(4'b0100, 1'b0, "rev_down");
        press(4'b0001, 1'b0, "same_up");
        press(4'b1000, 1'b0, "left");
        tick("t_left");
        press(4'b0001, 1'b0, "up2");
        tick("t_up2");

        // Two queued turns, overflow drop, then push during pop at full.
        press(4'b0010, 1'b0, "q_right");
        press(4'b0100, 1'b0, "q_down");
        press(4'b1000, 1'b0, "q_drop");
        press(4'b1000, 1'b1, "q_full_tick");
        tick("t_q1");
        tick("t_q2");
        tick("t_q3");

        // Push coinciding with a tick on an empty queue waits for the next tick.
        press(4'b0001, 1'b1, "tick_empty");
        reset = 1'b1;
        step(1);
        chk("rst2_dir", int'(direction), int'(DIR_TOP));
        chk("rst2_pend", int'(pending), 0);
        chk("rst2_dc", int'(dir_changed), 0);
        reset = 1'b0;
        mq.delete();
        m_dir = DIR_TOP;
        step(3);
        chk("rst2_after", int'(pending), 0);

        // Simultaneous presses: right beats left.
        press(4'b1010, 1'b0, "prio");
        tick("t_prio");

        // Back-to-back ticks pop independently.
        press(4'b0001, 1'b0, "bb_up");
        press(4'b1000, 1'b0, "bb_left");
        move_tick = 1'b1;
        step(1);
        model_edge(1'b1, 4'b0, drop);
        chk("bb_dir1", int'(direction), int'(m_dir));
        step(1);
        move_tick = 1'b0;
        model_edge(1'b1, 4'b0, drop);
        chk("bb_dir2", int'(direction), int'(m_dir));
        chk("bb_pend", int'(pending), 0);
        step(3);

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
